// File: rtl/com_store_buffer.sv
// Commit stage: in-order store FIFO drained to dmem over req/ack,
// store-to-load forwarding, retire back-pressure and commit counter.
//
// Ports:
//   CLK, RESET (async, active low), FREEZE (blocks acceptance only)
//   com_entry      registered commit entry from retire
//   dmem_req/addr/wdata, dmem_ack   memory write handshake
//   fwd_addr -> fwd_hit/fwd_data    youngest buffered store match
//   flush_fCOM     FIFO full, retire must hold
//   sb_empty       nothing buffered and no write in flight
//   commit_count   accepted instruction counter
//   debug          per-commit trace in simulation
module com_store_buffer #(
    parameter int COM_ENTRY_SIZE = 192,
    parameter int DEPTH          = 8,
    parameter int PTR_W          = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FREEZE,
    input  logic [COM_ENTRY_SIZE-1:0] com_entry,
    input  logic                      dmem_ack,
    input  logic [31:0]               fwd_addr,
    input  logic                      debug,
    output logic                      dmem_req,
    output logic [31:0]               dmem_addr,
    output logic [31:0]               dmem_wdata,
    output logic                      fwd_hit,
    output logic [31:0]               fwd_data,
    output logic                      flush_fCOM,
    output logic                      sb_empty,
    output logic [31:0]               commit_count
);

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] nxt_rd;
    logic [PTR_W:0]   count;
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [31:0] inst;
    logic [31:0] pc4;
    logic [31:0] st_data;
    logic [31:0] st_addr;
    logic        mem_write;
    logic        valid;
    logic        accept;
    logic        push;
    logic        pop;
    logic        unused_bits;

    assign inst      = com_entry[31:0];
    assign pc4       = com_entry[63:32];
    assign st_data   = com_entry[95:64];
    assign st_addr   = com_entry[127:96];
    assign mem_write = com_entry[133];

    assign unused_bits = ^{com_entry[COM_ENTRY_SIZE-1:134],
                           com_entry[132:128], pc4, debug};

    assign valid      = (inst != 32'd0);
    assign flush_fCOM = (count == CNT_FULL);
    assign accept     = valid & ~FREEZE & ~flush_fCOM;
    assign push       = accept & mem_write;
    assign pop        = (state == REQ) & dmem_ack;
    assign nxt_rd     = rd_ptr + PTR_W'(1);
    assign sb_empty   = (count == '0) & (state == IDLE);

    // Storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            commit_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) rd_ptr <= nxt_rd;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (accept) commit_count <= commit_count + 32'd1;
        end
    end

    // Head stays counted while in flight; on ack the next head is
    // reloaded only if it was already stored before this edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (count != '0) begin
                        dmem_req   <= 1'b1;
                        dmem_addr  <= addr_q[rd_ptr];
                        dmem_wdata <= data_q[rd_ptr];
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        if (count != CNT_ONE) begin
                            dmem_addr  <= addr_q[nxt_rd];
                            dmem_wdata <= data_q[nxt_rd];
                        end else begin
                            dmem_req <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Walk oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (((PTR_W + 1)'(k) < count) && (addr_q[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge CLK) begin
        if (debug && accept)
            $display("com pc=%h inst=%h st=%b n=%0d",
                     (pc4 == 32'd0) ? 32'd0 : pc4 - 32'd4,
                     inst, mem_write, commit_count + 32'd1);
    end
`endif

endmodule

// File: tb/tb_com_store_buffer.sv
// Bench for com_store_buffer: directed stores, scoreboard of expected
// memory writes checked by an independent handshake monitor.
module tb_com_store_buffer;

    logic         CLK;
    logic         RESET;
    logic         FREEZE;
    logic [191:0] com_entry;
    logic         dmem_ack;
    logic [31:0]  fwd_addr;
    logic         debug;
    logic         dmem_req;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic         fwd_hit;
    logic [31:0]  fwd_data;
    logic         flush_fCOM;
    logic         sb_empty;
    logic [31:0]  commit_count;

    com_store_buffer #(
        .COM_ENTRY_SIZE(192),
        .DEPTH(8),
        .PTR_W(3)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .FREEZE(FREEZE),
        .com_entry(com_entry),
        .dmem_ack(dmem_ack),
        .fwd_addr(fwd_addr),
        .debug(debug),
        .dmem_req(dmem_req),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .fwd_hit(fwd_hit),
        .fwd_data(fwd_data),
        .flush_fCOM(flush_fCOM),
        .sb_empty(sb_empty),
        .commit_count(commit_count)
    );

    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    logic [63:0] exp_q[$];
    int          hs_cyc[$];
    logic [31:0] exp_cc = 0;
    logic [31:0] pc = 32'h1000;

    initial CLK = 0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc_n = cyc_n + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Monitor: a write completes at the edge following req&ack.
    always @(negedge CLK) begin
        if (RESET && dmem_req && dmem_ack) begin
            hs_cyc.push_back(cyc_n);
            if (exp_q.size() == 0) begin
                chk("unexp_write", {63'd0, dmem_req}, 64'd0);
            end else begin
                chk("mem_write", {dmem_addr, dmem_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [191:0] mk(input logic [31:0] ins,
                                        input logic [31:0] p4,
                                        input logic [31:0] d,
                                        input logic [31:0] a,
                                        input logic mw);
        logic [191:0] e;
        e = '0;
        e[31:0] = ins;
        e[63:32] = p4;
        e[95:64] = d;
        e[127:96] = a;
        e[133] = mw;
        return e;
    endfunction

    // Present a store for the next edge; optionally log it as expected.
    task automatic put_st(input logic [31:0] a, input logic [31:0] d,
                          input bit expect_acc);
        pc = pc + 4;
        com_entry = mk(32'h00a12023, pc, d, a, 1'b1);
        if (expect_acc) begin
            exp_q.push_back({a, d});
            exp_cc = exp_cc + 1;
        end
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60; i++) begin
            if (sb_empty && exp_q.size() == 0) break;
            cyc();
        end
        chk(name, {62'd0, sb_empty, exp_q.size() == 0}, 64'd3);
    endtask

    initial begin
        int i;
        int guard;
        bit acc;
        RESET = 0;
        FREEZE = 0;
        com_entry = '0;
        dmem_ack = 0;
        fwd_addr = 0;
        debug = 0;
        cyc();
        cyc();
        chk("rst_req", {63'd0, dmem_req}, 0);
        chk("rst_empty", {63'd0, sb_empty}, 1);
        chk("rst_flush", {63'd0, flush_fCOM}, 0);
        chk("rst_cc", {32'd0, commit_count}, 0);
        chk("rst_fwd", {31'd0, fwd_hit, fwd_data}, 0);
        RESET = 1;
        cyc();

        // Reset during an outstanding write
        put_st(32'h100, 32'hAA, 1);
        cyc();
        com_entry = '0;
        cyc();
        cyc();
        cyc();
        chk("mid_req_up", {63'd0, dmem_req}, 1);
        RESET = 0;
        exp_q.delete();
        exp_cc = 0;
        #1;
        chk("mid_rst_req", {63'd0, dmem_req}, 0);
        chk("mid_rst_empty", {63'd0, sb_empty}, 1);
        chk("mid_rst_cc", {32'd0, commit_count}, 0);
        cyc();
        RESET = 1;
        dmem_ack = 1;
        for (int k = 0; k < 5; k++) cyc();
        chk("post_rst_req", {63'd0, dmem_req}, 0);

        // Back-to-back drain with ack tied high
        hs_cyc.delete();
        debug = 1;
        put_st(32'h10, 32'd1, 1);
        cyc();
        put_st(32'h14, 32'd2, 1);
        cyc();
        put_st(32'h18, 32'd3, 1);
        cyc();
        com_entry = '0;
        debug = 0;
        wait_empty("b2b_empty");
        chk("b2b_n", hs_cyc.size(), 3);
        if (hs_cyc.size() >= 3) begin
            chk("b2b_gap1", hs_cyc[1] - hs_cyc[0], 1);
            chk("b2b_gap2", hs_cyc[2] - hs_cyc[1], 1);
        end
        chk("b2b_cc", {32'd0, commit_count}, {32'd0, exp_cc});

        // Full FIFO back-pressure
        dmem_ack = 0;
        for (int k = 0; k < 8; k++) begin
            put_st(32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 1);
            cyc();
        end
        put_st(32'h300, 32'h9999, 0);
        chk("full_flush", {63'd0, flush_fCOM}, 1);
        chk("full_cc", {32'd0, commit_count}, {32'd0, exp_cc});
        cyc();
        cyc();
        chk("full_hold_cc", {32'd0, commit_count}, {32'd0, exp_cc});
        dmem_ack = 1;
        cyc();
        dmem_ack = 0;
        chk("full_release", {63'd0, flush_fCOM}, 0);
        exp_q.push_back({32'h300, 32'h9999});
        exp_cc = exp_cc + 1;
        cyc();
        com_entry = '0;
        chk("ninth_cc", {32'd0, commit_count}, {32'd0, exp_cc});
        chk("refull_flush", {63'd0, flush_fCOM}, 1);
        dmem_ack = 1;
        wait_empty("full_drain");

        // Forwarding picks the youngest match
        dmem_ack = 0;
        put_st(32'h40, 32'h11, 1);
        cyc();
        put_st(32'h40, 32'h22, 1);
        cyc();
        com_entry = '0;
        fwd_addr = 32'h40;
        #1;
        chk("fwd_young", {31'd0, fwd_hit, fwd_data}, {31'd0, 1'b1, 32'h22});
        fwd_addr = 32'h44;
        #1;
        chk("fwd_miss", {31'd0, fwd_hit, fwd_data}, 0);
        fwd_addr = 32'h50;
        put_st(32'h50, 32'h55, 1);
        #1;
        chk("fwd_same_cyc", {63'd0, fwd_hit}, 0);
        cyc();
        com_entry = '0;
        chk("fwd_next_cyc", {31'd0, fwd_hit, fwd_data}, {31'd0, 1'b1, 32'h55});
        dmem_ack = 1;
        wait_empty("fwd_drain");
        fwd_addr = 32'h40;
        #1;
        chk("fwd_after_drain", {63'd0, fwd_hit}, 0);
        fwd_addr = 0;

        // FREEZE and bubbles
        dmem_ack = 0;
        com_entry = mk(32'h00000013, 32'h2004, 32'h5, 32'h300, 1'b0);
        FREEZE = 1;
        cyc();
        cyc();
        FREEZE = 0;
        cyc();
        cyc();
        exp_cc = exp_cc + 2;
        com_entry = '0;
        cyc();
        chk("frz_cc", {32'd0, commit_count}, {32'd0, exp_cc});
        chk("frz_empty", {63'd0, sb_empty}, 1);
        fwd_addr = 32'h300;
        #1;
        chk("frz_nofwd", {63'd0, fwd_hit}, 0);
        fwd_addr = 0;
        put_st(32'h60, 32'h66, 1);
        cyc();
        put_st(32'h64, 32'h77, 1);
        cyc();
        put_st(32'h68, 32'h88, 0);
        FREEZE = 1;
        dmem_ack = 1;
        wait_empty("frz_drain");
        chk("frz_store_cc", {32'd0, commit_count}, {32'd0, exp_cc});
        com_entry = '0;
        FREEZE = 0;
        cyc();

        // Pointer wrap with random ack gaps
        i = 0;
        guard = 0;
        while (i < 20 && guard < 2000) begin
            dmem_ack = 1'($urandom_range(0, 1));
            acc = !flush_fCOM;
            put_st(32'h800 + 32'(4 * i), 32'hC000 + 32'(i), acc);
            cyc();
            if (acc) i++;
            guard++;
        end
        chk("wrap_pushed", 64'(i), 64'd20);
        com_entry = '0;
        dmem_ack = 1;
        wait_empty("wrap_drain");
        chk("wrap_cc", {32'd0, commit_count}, {32'd0, exp_cc});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
